// File: rtl/psum_reduce_pkg.sv
// psum_reduce_pkg: shared FSM state type, result-width helper and saturation bounds for psum_reduce_hub
package psum_reduce_pkg;
  typedef enum logic [1:0] {COLLECT, REDUCE, HOLD} state_t;
  localparam int BW_PSUM_DEF = 19;
  localparam int SUM_W_DEF = BW_PSUM_DEF + 4;
  function automatic int acc_w(int n_core, int sum_w);
    return sum_w + $clog2(n_core);
  endfunction
  function automatic longint sat_hi(int sum_w);
    return (longint'(1) <<< (sum_w - 1)) - 1;
  endfunction
  function automatic longint sat_lo(int sum_w);
    return -(longint'(1) <<< (sum_w - 1));
  endfunction
  localparam longint SAT_HI_DEF = sat_hi(SUM_W_DEF);
  localparam longint SAT_LO_DEF = sat_lo(SUM_W_DEF);
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: first-word-fall-through sync FIFO for one core's partial sums
// Ports: clk, reset (sync, active-high), i_push/i_din write side, i_pop read side,
//        o_head current head word, o_full/o_empty occupancy flags.
// A pop and a push in the same cycle both take effect, even when full.
module psum_fifo #(
  parameter int W = 23,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_head = r_mem[r_rp];
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/psum_reduce_hub.sv
// psum_reduce_hub: N-core partial-sum FIFO/reduce/broadcast hub with per-core acknowledge
// Ports: clk, reset (sync, active-high); core_mask participation; wr_sum/sum_in/wr_ready per-core push;
//        sum_out/sum_out_valid broadcast result; rd_sum per-core ack; overflow sticky drop flags;
//        sat_flag sticky clamp flag.
// Build option: define PSUM_SATURATE_EN to clamp results to the signed SUM_W range.
module psum_reduce_hub
  import psum_reduce_pkg::*;
#(
  parameter int N_CORE = 2,
  parameter int BW_PSUM = BW_PSUM_DEF,
  parameter int SUM_W = BW_PSUM + 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W = acc_w(N_CORE, SUM_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CORE-1:0]       core_mask,
  input  logic [N_CORE-1:0]       wr_sum,
  input  logic [N_CORE*SUM_W-1:0] sum_in,
  output logic [N_CORE-1:0]       wr_ready,
  output logic [ACC_W-1:0]        sum_out,
  output logic                    sum_out_valid,
  input  logic [N_CORE-1:0]       rd_sum,
  output logic [N_CORE-1:0]       overflow,
  output logic                    sat_flag
);
  state_t r_state;
  logic [N_CORE-1:0] r_mask, r_ack, r_ovf;
  logic [N_CORE-1:0] w_full, w_empty, w_pop;
  logic [SUM_W-1:0] w_head [N_CORE];
  logic [ACC_W-1:0] r_sum;
  logic r_valid;
  logic signed [ACC_W-1:0] w_sum, w_res;
  assign w_pop = (r_state == REDUCE) ? r_mask : '0;
  assign wr_ready = reset ? '0 : (~w_full | w_pop);
  for (genvar g = 0; g < N_CORE; g++) begin : g_fifo
    psum_fifo #(.W(SUM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .i_push(wr_sum[g]),
      .i_pop(w_pop[g]),
      .i_din(sum_in[g*SUM_W +: SUM_W]),
      .o_head(w_head[g]),
      .o_full(w_full[g]),
      .o_empty(w_empty[g])
    );
  end
  // unmasked lanes contribute zero; heads are sign-extended to ACC_W
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CORE; i++)
      w_sum = w_sum + (r_mask[i] ? {{(ACC_W-SUM_W){w_head[i][SUM_W-1]}}, w_head[i]} : '0);
  end
`ifdef PSUM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(SUM_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(SUM_W));
  logic r_sat, w_hi, w_lo;
  assign w_hi = w_sum > SAT_HI;
  assign w_lo = w_sum < SAT_LO;
  assign w_res = w_hi ? SAT_HI : w_lo ? SAT_LO : w_sum;
  assign sat_flag = r_sat;
  always_ff @(posedge clk) begin
    if (reset) r_sat <= 1'b0;
    else if (r_state == REDUCE && (w_hi || w_lo)) r_sat <= 1'b1;
  end
`else
  assign w_res = w_sum;
  assign sat_flag = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
      r_mask <= '0;
      r_ack <= '0;
      r_ovf <= '0;
      r_sum <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (wr_sum & w_full & ~w_pop);
      case (r_state)
        COLLECT:
          if (core_mask != '0 && (core_mask & w_empty) == '0) begin
            r_mask <= core_mask;
            r_state <= REDUCE;
          end
        REDUCE: begin
          r_sum <= w_res;
          r_valid <= 1'b1;
          r_ack <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          r_ack <= r_ack | (rd_sum & r_mask);
          if (((r_ack | rd_sum) & r_mask) == r_mask) begin
            r_valid <= 1'b0;
            r_state <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end
  assign sum_out = r_sum;
  assign sum_out_valid = r_valid;
  assign overflow = r_ovf;
endmodule
